// File: rtl/llr_frame_collector.sv
// Collects demodulator symbols (LLR + hard bit) into FRAME_LEN-symbol frames,
// buffers them in a small FIFO and flags protocol errors on accepted symbols.
module llr_frame_collector #(
    parameter int LLR_W      = 8,
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_rd_vld,
    input  logic [LLR_W-1:0]           i_llr,
    input  logic                       i_hard_bit,
    output logic                       o_rd_rdy,
    output logic                       o_frm_vld,
    input  logic                       i_frm_rdy,
    output logic [LLR_W*FRAME_LEN-1:0] o_frm_llr,
    output logic [FRAME_LEN-1:0]       o_frm_hb,
    output logic                       o_err_zero,
    output logic                       o_err_sign,
    input  logic                       i_clr_err,
    output logic [15:0]                o_frm_cnt
);

    localparam int SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FRM_W  = LLR_W * FRAME_LEN;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [FRM_W-1:0]     asm_llr_q, asm_llr_d;
    logic [FRAME_LEN-1:0] asm_hb_q, asm_hb_d;
    logic [FRM_W-1:0]     mem_llr_q [FIFO_DEPTH];
    logic [FRAME_LEN-1:0] mem_hb_q  [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                 err_zero_q, err_zero_d;
    logic                 err_sign_q, err_sign_d;
    logic [15:0]          frm_cnt_q, frm_cnt_d;

    logic fifo_empty, fifo_full, rd_rdy, accept, complete, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_rdy     = (slot_q != LAST_SLOT) | ~fifo_full;
    assign accept     = i_rd_vld & rd_rdy;
    assign complete   = accept & (slot_q == LAST_SLOT);
    assign pop        = ~fifo_empty & i_frm_rdy;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    always_comb begin
        slot_d    = slot_q;
        asm_llr_d = asm_llr_q;
        asm_hb_d  = asm_hb_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        frm_cnt_d = frm_cnt_q;

        if (accept) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (slot_q == SLOT_W'(k)) begin
                    asm_llr_d[k*LLR_W +: LLR_W] = i_llr;
                    asm_hb_d[k]                 = i_hard_bit;
                end
            end
            slot_d = complete ? '0 : slot_q + SLOT_W'(1);
        end

        if (complete) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
            frm_cnt_d = frm_cnt_q + 16'd1;
        end

        // A fresh error on this edge wins over a simultaneous clear.
        err_zero_d = (err_zero_q & ~i_clr_err) | (accept & (i_llr == '0));
        err_sign_d = (err_sign_q & ~i_clr_err) | (accept & (i_llr[LLR_W-1] != i_hard_bit));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            slot_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_zero_q <= 1'b0;
            err_sign_q <= 1'b0;
            frm_cnt_q  <= '0;
        end else begin
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_zero_q <= err_zero_d;
            err_sign_q <= err_sign_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    // NOTE: the assembly buffer and FIFO storage are not reset; the slot
    // counter and pointers decide what is valid, and empty output is forced to 0.
    always_ff @(posedge i_clk) begin
        asm_llr_q <= asm_llr_d;
        asm_hb_q  <= asm_hb_d;
        if (complete) begin
            mem_llr_q[wr_ptr_q[PTR_W-1:0]] <= asm_llr_d;
            mem_hb_q[wr_ptr_q[PTR_W-1:0]]  <= asm_hb_d;
        end
    end

    assign o_rd_rdy   = rd_rdy;
    assign o_frm_vld  = ~fifo_empty;
    assign o_frm_llr  = fifo_empty ? '0 : mem_llr_q[rd_ptr_q[PTR_W-1:0]];
    assign o_frm_hb   = fifo_empty ? '0 : mem_hb_q[rd_ptr_q[PTR_W-1:0]];
    assign o_err_zero = err_zero_q;
    assign o_err_sign = err_sign_q;
    assign o_frm_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_llr_frame_collector.sv
// Self-checking bench for llr_frame_collector: vector table for single-frame and
// error-flag behaviour, hand sequences for reset, backpressure, streaming, mid-frame reset.
module tb_llr_frame_collector;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_rd_vld = 1'b0;
    logic [7:0]  i_llr = '0;
    logic        i_hard_bit = 1'b0;
    logic        o_rd_rdy;
    logic        o_frm_vld;
    logic        i_frm_rdy = 1'b0;
    logic [63:0] o_frm_llr;
    logic [7:0]  o_frm_hb;
    logic        o_err_zero;
    logic        o_err_sign;
    logic        i_clr_err = 1'b0;
    logic [15:0] o_frm_cnt;

    int checks = 0;
    int errors = 0;

    llr_frame_collector #(.LLR_W(8), .FRAME_LEN(8), .FIFO_DEPTH(4)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_vld   (i_rd_vld),
        .i_llr      (i_llr),
        .i_hard_bit (i_hard_bit),
        .o_rd_rdy   (o_rd_rdy),
        .o_frm_vld  (o_frm_vld),
        .i_frm_rdy  (i_frm_rdy),
        .o_frm_llr  (o_frm_llr),
        .o_frm_hb   (o_frm_hb),
        .o_err_zero (o_err_zero),
        .o_err_sign (o_err_sign),
        .i_clr_err  (i_clr_err),
        .o_frm_cnt  (o_frm_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rd_vld;
        logic [7:0]  llr;
        logic        hb;
        logic        frm_rdy;
        logic        clr;
        logic        e_rdy;
        logic        e_vld;
        logic [63:0] e_llr;
        logic [7:0]  e_hb;
        logic        e_zero;
        logic        e_sign;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic rd_vld, input logic [7:0] llr, input logic hb,
                       input logic frm_rdy, input logic clr, input logic e_rdy,
                       input logic e_vld, input logic [63:0] e_llr, input logic [7:0] e_hb,
                       input logic e_zero, input logic e_sign, input logic [15:0] e_cnt);
        vec_t v;
        v = '{rd_vld, llr, hb, frm_rdy, clr, e_rdy, e_vld, e_llr, e_hb, e_zero, e_sign, e_cnt};
        tbl.push_back(v);
    endtask

    task automatic check_head(input string name, input logic [63:0] e_llr, input logic [7:0] e_hb);
        check({name, "_vld"}, 64'(o_frm_vld), 64'd1);
        check({name, "_llr"}, o_frm_llr, e_llr);
        check({name, "_hb"},  64'(o_frm_hb), 64'(e_hb));
    endtask

    // Backpressure frames: frame f, slot k carries LLR {f, k+1}; hard bit = 0 (matching sign).
    function automatic logic [7:0] bp_sym(input int f, input int k);
        return 8'((f << 4) | (k + 1));
    endfunction

    function automatic logic [63:0] bp_frame(input int f);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = bp_sym(f, k);
        return r;
    endfunction

    task automatic send_sym(input logic [7:0] llr, input logic hb);
        check("send_rdy", 64'(o_rd_rdy), 64'd1);
        i_rd_vld = 1'b1; i_llr = llr; i_hard_bit = hb;
        step();
        i_rd_vld = 1'b0;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        #2;
        i_reset = 1'b0;
        step();
    endtask

    initial begin
        logic [63:0] q_llr[$];
        logic [7:0]  q_hb[$];
        logic [63:0] a_llr;
        logic [7:0]  a_hb;
        int a_n, pushed, popped, cyc;
        logic acc, pop, e_rdy;
        logic [15:0] exp_cnt;

        // ---------------- vector table ----------------
        for (int i = 0; i < 8; i++)
            add(1, 8'(8'h81 + i), 1, 1, 0, 1, (i == 7), (i == 7) ? 64'h8887868584838281 : 64'h0,
                (i == 7) ? 8'hFF : 8'h00, 0, 0, 16'd0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 64'h0, 8'h00, 0, 0, 16'd1);
        add(1, 8'h00, 0, 0, 0, 1, 0, 64'h0, 8'h00, 1, 0, 16'd1);
        add(1, 8'h7F, 1, 0, 0, 1, 0, 64'h0, 8'h00, 1, 1, 16'd1);
        add(0, 8'h00, 0, 0, 1, 1, 0, 64'h0, 8'h00, 0, 0, 16'd1);
        add(0, 8'h00, 1, 0, 0, 1, 0, 64'h0, 8'h00, 0, 0, 16'd1);
        add(1, 8'h00, 0, 0, 1, 1, 0, 64'h0, 8'h00, 1, 0, 16'd1);
        add(1, 8'h05, 1, 0, 1, 1, 0, 64'h0, 8'h00, 0, 1, 16'd1);
        add(0, 8'h00, 0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 16'd1);
        add(1, 8'h80, 0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 16'd1);
        add(1, 8'h11, 0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 16'd1);
        add(1, 8'h22, 0, 0, 0, 1, 0, 64'h0, 8'h00, 0, 1, 16'd1);
        add(1, 8'h33, 0, 1, 0, 1, 1, 64'h3322118005007F00, 8'h0A, 0, 1, 16'd1);
        add(0, 8'h00, 0, 1, 1, 1, 0, 64'h0, 8'h00, 0, 0, 16'd2);

        // ---------------- reset check ----------------
        #2;
        i_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_rd_vld = 1'($urandom); i_llr = 8'($urandom); i_hard_bit = 1'($urandom);
            i_frm_rdy = 1'($urandom); i_clr_err = 1'($urandom);
            step();
            check("rst_rd_rdy",   64'(o_rd_rdy),   64'd1);
            check("rst_frm_vld",  64'(o_frm_vld),  64'd0);
            check("rst_frm_llr",  o_frm_llr,       64'd0);
            check("rst_frm_hb",   64'(o_frm_hb),   64'd0);
            check("rst_err_zero", 64'(o_err_zero), 64'd0);
            check("rst_err_sign", 64'(o_err_sign), 64'd0);
            check("rst_frm_cnt",  64'(o_frm_cnt),  64'd0);
        end
        i_rd_vld = 1'b0; i_frm_rdy = 1'b0; i_clr_err = 1'b0;
        i_reset = 1'b0;
        step();
        check("post_rst_rd_rdy",  64'(o_rd_rdy),  64'd1);
        check("post_rst_frm_vld", 64'(o_frm_vld), 64'd0);

        // ---------------- table-driven: single frame + error flags ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            i_rd_vld = tbl[i].rd_vld; i_llr = tbl[i].llr; i_hard_bit = tbl[i].hb;
            i_frm_rdy = tbl[i].frm_rdy; i_clr_err = tbl[i].clr;
            step();
            check($sformatf("vec%0d_rd_rdy", i),   64'(o_rd_rdy),   64'(tbl[i].e_rdy));
            check($sformatf("vec%0d_frm_vld", i),  64'(o_frm_vld),  64'(tbl[i].e_vld));
            check($sformatf("vec%0d_frm_llr", i),  o_frm_llr,       tbl[i].e_llr);
            check($sformatf("vec%0d_frm_hb", i),   64'(o_frm_hb),   64'(tbl[i].e_hb));
            check($sformatf("vec%0d_err_zero", i), 64'(o_err_zero), 64'(tbl[i].e_zero));
            check($sformatf("vec%0d_err_sign", i), 64'(o_err_sign), 64'(tbl[i].e_sign));
            check($sformatf("vec%0d_frm_cnt", i),  64'(o_frm_cnt),  64'(tbl[i].e_cnt));
        end
        i_rd_vld = 1'b0; i_frm_rdy = 1'b0; i_clr_err = 1'b0;
        exp_cnt = 16'd2;

        // ---------------- backpressure ----------------
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 8; k++) send_sym(bp_sym(f, k), 1'b0);
        for (int k = 0; k < 7; k++) send_sym(bp_sym(4, k), 1'b0);
        check("bp_full_rd_rdy", 64'(o_rd_rdy), 64'd0);
        check_head("bp_head0", bp_frame(0), 8'h00);
        i_rd_vld = 1'b1; i_llr = bp_sym(4, 7); i_hard_bit = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            check("bp_stall_rd_rdy", 64'(o_rd_rdy), 64'd0);
            check_head("bp_stall_head", bp_frame(0), 8'h00);
        end
        i_frm_rdy = 1'b1;
        step();
        i_frm_rdy = 1'b0;
        exp_cnt++;
        check("bp_release_rd_rdy", 64'(o_rd_rdy), 64'd1);
        check_head("bp_head1", bp_frame(1), 8'h00);
        step();
        i_rd_vld = 1'b0;
        check("bp_after_8th_rd_rdy", 64'(o_rd_rdy), 64'd1);
        i_frm_rdy = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            check_head($sformatf("bp_drain%0d", f), bp_frame(f), 8'h00);
            step();
            exp_cnt++;
        end
        i_frm_rdy = 1'b0;
        check("bp_drained_vld", 64'(o_frm_vld), 64'd0);
        check("bp_frm_cnt", 64'(o_frm_cnt), 64'(exp_cnt));
        check("bp_no_err", 64'({o_err_zero, o_err_sign}), 64'd0);

        // ---------------- streaming against a reference model ----------------
        pulse_reset();
        check("stream_start_cnt", 64'(o_frm_cnt), 64'd0);
        a_llr = '0; a_hb = '0; a_n = 0; pushed = 0; popped = 0; cyc = 0;
        while (popped < 1000 && cyc < 60000) begin
            i_rd_vld   = (pushed < 1000) && ($urandom_range(0, 3) == 0);
            i_llr      = 8'($urandom);
            i_hard_bit = 1'($urandom);
            i_frm_rdy  = 1'($urandom);
            e_rdy = (a_n != 7) || (q_llr.size() != 4);
            if (o_rd_rdy !== e_rdy) check("stream_rd_rdy", 64'(o_rd_rdy), 64'(e_rdy));
            if (o_frm_vld !== (q_llr.size() != 0))
                check("stream_frm_vld", 64'(o_frm_vld), 64'(q_llr.size() != 0));
            acc = i_rd_vld & o_rd_rdy;
            pop = o_frm_vld & i_frm_rdy;
            if (pop && q_llr.size() != 0) begin
                check("stream_frm_llr", o_frm_llr, q_llr[0]);
                check("stream_frm_hb", 64'(o_frm_hb), 64'(q_hb[0]));
                void'(q_llr.pop_front());
                void'(q_hb.pop_front());
                popped++;
            end
            if (acc) begin
                a_llr[a_n*8 +: 8] = i_llr;
                a_hb[a_n] = i_hard_bit;
                a_n++;
                if (a_n == 8) begin
                    q_llr.push_back(a_llr);
                    q_hb.push_back(a_hb);
                    a_n = 0;
                    pushed++;
                end
            end
            step();
            cyc++;
        end
        i_rd_vld = 1'b0; i_frm_rdy = 1'b0;
        check("stream_frames_popped", 64'(popped), 64'd1000);
        check("stream_frm_cnt", 64'(o_frm_cnt), 64'h03E8);
        check("stream_empty", 64'(o_frm_vld), 64'd0);

        // ---------------- mid-frame reset ----------------
        for (int k = 0; k < 8; k++) send_sym(bp_sym(2, k), 1'b0);
        for (int k = 0; k < 3; k++) send_sym(8'hA0 + 8'(k), 1'b1);
        check("mid_pre_rst_vld", 64'(o_frm_vld), 64'd1);
        pulse_reset();
        check("mid_rst_vld", 64'(o_frm_vld), 64'd0);
        check("mid_rst_cnt", 64'(o_frm_cnt), 64'd0);
        for (int k = 0; k < 8; k++) begin
            send_sym(8'(k + 1), 1'b0);
            if (k < 7) check("mid_no_early_frame", 64'(o_frm_vld), 64'd0);
        end
        check_head("mid_frame", 64'h0807060504030201, 8'h00);
        i_frm_rdy = 1'b1;
        step();
        i_frm_rdy = 1'b0;
        check("mid_single_frame", 64'(o_frm_vld), 64'd0);
        check("mid_frm_cnt", 64'(o_frm_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/llr_frame_collector.md
Name: llr_frame_collector

Overview:
- Consumer end of the ml_demodulator output stream: drives o_rd_rdy and accepts one (LLR, hard bit) symbol per handshake.
- Packs each group of FRAME_LEN symbols into one frame: a 64-bit LLR vector and an 8-bit hard-bit byte.
- Buffers complete frames in a small FIFO and presents them to the downstream decoder on a valid/ready interface.
- Checks each accepted symbol for protocol errors (LLR equal to zero, LLR sign disagreeing with the hard bit) and flags them stickily.

Parameters:
- LLR_W, 8, width of one LLR word (two's complement).
- FRAME_LEN, 8, symbols per frame.
- FIFO_DEPTH, 4, frame FIFO entries (power of two, at least 2).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rd_vld  in  1  symbol valid from the demodulator.
- i_llr  in  LLR_W  symbol LLR.
- i_hard_bit  in  1  symbol hard decision.
- o_rd_rdy  out  1  symbol ready to the demodulator.
- o_frm_vld  out  1  frame valid (FIFO not empty).
- i_frm_rdy  in  1  downstream ready for a frame.
- o_frm_llr  out  LLR_W*FRAME_LEN  head frame LLRs; slot k occupies [LLR_W*(k+1)-1 -: LLR_W].
- o_frm_hb  out  FRAME_LEN  head frame hard bits; bit k = slot k.
- o_err_zero  out  1  sticky flag: an accepted LLR was 0.
- o_err_sign  out  1  sticky flag: an accepted LLR's MSB differed from its hard bit.
- i_clr_err  in  1  clears both sticky flags.
- o_frm_cnt  out  16  count of frames popped downstream, wraps modulo 2^16.

Behaviour:
- Reset is i_reset, asynchronous, active-high; the clock is i_clk.
- Reset values:
  - o_rd_rdy=1 (combinational from reset-state registers).
  - o_frm_vld=0, o_frm_llr=0, o_frm_hb=0.
  - o_err_zero=0, o_err_sign=0, o_frm_cnt=0.
  - Slot counter=0; FIFO empty.
- Symbol handshake: accept = i_rd_vld & o_rd_rdy, sampled on the rising edge.
  - i_llr and i_hard_bit are ignored when accept=0.
- Assembly state is the slot counter, 0..FRAME_LEN-1.
  - On accept with slot<FRAME_LEN-1: store the symbol into slot, slot+1.
  - On accept with slot=FRAME_LEN-1 (COMPLETE): write {stored slots 0..6, current symbol} into the FIFO in the same edge, and slot returns to 0.
  - The assembly register is not cleared between frames; only the FIFO copy is observable.
- o_rd_rdy = (slot != FRAME_LEN-1) | ~fifo_full. It is purely a function of registers, with no combinational path from i_frm_rdy or i_rd_vld.
  - When the FIFO is full, up to FRAME_LEN-1 symbols are still accepted; the final symbol stalls.
- Frame output: o_frm_vld = ~fifo_empty; o_frm_llr and o_frm_hb show the head entry whenever o_frm_vld=1, and 0 when empty.
  - Pop = o_frm_vld & i_frm_rdy.
  - Head data is held stable while o_frm_vld=1 and i_frm_rdy=0.
- Latency: a frame completed on edge N with an empty FIFO gives o_frm_vld=1 after edge N, i.e. visible in the following cycle.
- FIFO boundaries:
  - Push and pop on the same edge: occupancy unchanged; order preserved.
  - A push while full cannot occur, because it is blocked by o_rd_rdy.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Frames leave in strict arrival order.
- o_frm_cnt increments by 1 on every pop, wrapping 0xFFFF to 0x0000.
- Error checks apply to every accepted symbol. The symbol is still stored and framed normally.
  - i_llr==0 sets o_err_zero on that edge.
  - i_llr[LLR_W-1] != i_hard_bit sets o_err_sign on that edge.
  - i_clr_err=1 clears both flags, unless a new error is detected on the same edge; set wins for that flag.
- Reset mid-operation discards the partial frame and all FIFO contents. The first accepted symbol after reset is slot 0.

Test Plan:
- Reset check: assert i_reset for 4 cycles with random inputs -> all outputs at reset values during reset; o_rd_rdy=1 and o_frm_vld=0 after release.
- Single frame: 8 back-to-back symbols with LLR 0x81..0x88 and hb=1, i_frm_rdy=1 -> o_frm_vld=1 for exactly one cycle, starting the cycle after the 8th handshake.
  - That cycle: o_frm_llr=0x8887868584838281, o_frm_hb=0xFF.
  - No error flags set; o_frm_cnt=1.
- Backpressure: i_frm_rdy=0, push 4 frames, then 7 symbols -> o_rd_rdy=0 at slot 7 and the head frame stays stable.
  - Pulse i_frm_rdy for one cycle -> o_rd_rdy=1 on the next cycle and the 8th symbol is accepted.
  - Frames then drain in order; o_frm_cnt=5.
- Errors: accept LLR=0x00 with hb=0 -> o_err_zero=1 the next cycle.
  - Accept LLR=0x7F with hb=1 -> o_err_sign=1.
  - Assert i_clr_err alone -> both flags 0.
  - Assert i_clr_err on the same edge as an LLR=0x00 symbol -> o_err_zero remains 1.
- Streaming: 1000 frames with random i_rd_vld (25% duty) and random i_frm_rdy, checked against a reference model -> every frame matches, no symbol lost or duplicated, o_frm_cnt=0x03E8.
- Mid-frame reset: accept 3 symbols, pulse i_reset, then send 8 symbols 0x01..0x08 with hb=0 -> exactly one frame, o_frm_llr=0x0807060504030201, o_frm_hb=0x00.
